flush_ctrl: RTL and testbench
=============================

FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have a port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have a port wb_ex, input, 1 bit: WB stage commits an exception (already qualified by the WB valid bit).
REQ-004 The block SHALL have a port wb_ex_pc, input, 32 bits: PC of the excepting instruction.
REQ-005 The block SHALL have a port wb_ecode, input, 6 bits: exception code of the excepting instruction.
REQ-006 The block SHALL have a port ertn_flush, input, 1 bit: WB stage commits an ertn (already qualified by the WB valid bit).
REQ-007 The block SHALL have a port csr_eentry, input, 32 bits: current EENTRY CSR value.
REQ-008 The block SHALL have a port csr_era, input, 32 bits: current ERA CSR value.
REQ-009 The block SHALL have a port if_redirect_ready, input, 1 bit: IF stage accepts the redirect in this cycle.
REQ-010 The block SHALL have a port flush, output, 1 bit: one-cycle pulse that kills all instructions in the IF, ID, EX and MEM stages.
REQ-011 The block SHALL have a port redirect_valid, output, 1 bit: a redirect target is being presented to IF.
REQ-012 The block SHALL have a port redirect_pc, output, 32 bits: the redirect target.
REQ-013 The block SHALL have a port busy, output, 1 bit: high in any state other than IDLE; used to force wb_allowin low.
REQ-014 The block SHALL have a port last_ex_pc, output, 32 bits: PC of the most recently accepted exception.
REQ-015 The block SHALL have a port last_ecode, output, 6 bits: ecode of the most recently accepted exception.
REQ-016 The block SHALL have a port ex_count, output, 16 bits: number of exceptions accepted.
REQ-017 The block SHALL have a port ertn_count, output, 16 bits: number of ertn events accepted.

Function
REQ-018 The FSM SHALL have three states, IDLE, FLUSH and REDIRECT, and SHALL be encoded in registers.
REQ-019 In IDLE, when wb_ex=1, the FSM SHALL go to FLUSH next cycle.
- Same edge: latch target = {csr_eentry[31:2], 2'b00}, latch last_ex_pc = wb_ex_pc, latch last_ecode = wb_ecode, ex_count += 1.
REQ-020 In IDLE, when wb_ex=0 and ertn_flush=1, the FSM SHALL go to FLUSH next cycle.
- Same edge: latch target = {csr_era[31:2], 2'b00}, ertn_count += 1.
REQ-021 If wb_ex and ertn_flush are high in the same cycle, wb_ex SHALL win; ertn_flush is dropped and ertn_count is unchanged.
REQ-022 In FLUSH, flush SHALL be 1 for exactly that one cycle, and the FSM SHALL unconditionally go to REDIRECT.
REQ-023 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc SHALL equal the latched target, held stable until accepted.
REQ-024 In REDIRECT, when if_redirect_ready=1, the FSM SHALL return to IDLE next cycle; otherwise it SHALL remain in REDIRECT indefinitely.
REQ-025 redirect_valid SHALL be 0 in IDLE and FLUSH; redirect_pc SHALL hold its last latched value in those states.
REQ-026 wb_ex and ertn_flush arriving while busy=1 SHALL be ignored: no state change, no counter change, no latch update.
REQ-027 Minimum event latency SHALL be 3 cycles: event cycle (IDLE), FLUSH, then REDIRECT accepted in the same cycle it is entered.
REQ-028 A new event in the cycle after returning to IDLE SHALL be accepted normally.
REQ-029 ex_count and ertn_count SHALL wrap from 16'hFFFF to 16'h0000 without saturating or raising any flag.
REQ-030 csr_eentry and csr_era SHALL be sampled only on the acceptance edge; later changes to them SHALL NOT affect redirect_pc.

Reset
REQ-031 While resetn=0, asynchronously: state=IDLE; flush=0, redirect_valid=0, busy=0; redirect_pc=0, last_ex_pc=0, last_ecode=0, ex_count=0, ertn_count=0.
REQ-032 Reset asserted in FLUSH or REDIRECT SHALL abort the sequence immediately, with no flush pulse and no redirect after release.
REQ-033 The first edge after reset release SHALL be able to accept an event.

Verification
REQ-034 The bench SHALL cover the basic exception: csr_eentry=0x1C008000, wb_ex=1 with wb_ex_pc=0x1C000100 and wb_ecode=0x0B for 1 cycle, if_redirect_ready=1 -> flush pulse at cycle+1; redirect_valid=1 with redirect_pc=0x1C008000 at cycle+2; IDLE at cycle+3; ex_count=1; last_ecode=0x0B.
REQ-035 The bench SHALL cover ertn alignment: csr_era=0x1C000107, ertn_flush=1 -> redirect_pc=0x1C000104; ertn_count=1.
REQ-036 The bench SHALL cover the simultaneous case: wb_ex=1 and ertn_flush=1 -> target is EENTRY; ex_count+1; ertn_count unchanged.
REQ-037 The bench SHALL cover redirect backpressure: if_redirect_ready=0 for 5 cycles -> redirect_valid and busy held 5 cycles with redirect_pc stable; a wb_ex pulse during that window is ignored; csr_eentry changes do not alter redirect_pc.
REQ-038 The bench SHALL cover counter wrap: preload ex_count to 0xFFFF via 65535 events -> next accepted event gives ex_count=0x0000.
REQ-039 The bench SHALL cover reset mid-operation: resetn=0 asserted in REDIRECT -> all outputs 0 immediately (asynchronously); after release, no redirect_valid until a new event.

Source files
------------

// File: rtl/flush_ctrl.sv
// flush_ctrl
//   Sequences the pipeline flush and IF redirect that follow a committed
//   exception or ertn. An event accepted in IDLE latches the redirect target
//   (and, for exceptions, the PC/ecode and count). One cycle of flush then
//   follows. After that the target is presented to IF until IF accepts it.
//   busy stays high for the whole sequence so that WB is stalled. Events that
//   arrive while busy is high are dropped.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for wb_ex / ertn_flush; redirect_valid low
//   FLUSH    | flush pulse asserted for this single cycle
//   REDIRECT | redirect_valid high with a stable target until accepted
//
// Ports
//   clk, resetn        clock, async active-low reset
//   wb_ex              WB commits an exception (valid-qualified)
//   wb_ex_pc/wb_ecode  PC and ecode of the excepting instruction
//   ertn_flush         WB commits an ertn (valid-qualified)
//   csr_eentry/csr_era exception entry / return address CSRs
//   if_redirect_ready  IF accepts the redirect this cycle
//   flush              one-cycle kill of IF/ID/EX/MEM
//   redirect_valid/pc  redirect presented to IF
//   busy               sequence in progress (not IDLE)
//   last_ex_pc/ecode   details of the most recent accepted exception
//   ex_count/ertn_count wrapping event counters
module flush_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic [31:0] wb_ex_pc,
  input  logic [5:0]  wb_ecode,
  input  logic        ertn_flush,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        if_redirect_ready,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] last_ex_pc,
  output logic [5:0]  last_ecode,
  output logic [15:0] ex_count,
  output logic [15:0] ertn_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state;

  // All outputs are registers. redirect_pc is the latched target, so it is
  // already stable during FLUSH. It keeps its value after the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
      redirect_pc    <= 32'h0;
      last_ex_pc     <= 32'h0;
      last_ecode     <= 6'h0;
      ex_count       <= 16'h0;
      ertn_count     <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          // The exception has priority. An ertn in the same cycle is dropped.
          if (wb_ex) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            busy        <= 1'b1;
            redirect_pc <= {csr_eentry[31:2], 2'b00};
            last_ex_pc  <= wb_ex_pc;
            last_ecode  <= wb_ecode;
            ex_count    <= ex_count + 16'd1;
          end else if (ertn_flush) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            busy        <= 1'b1;
            redirect_pc <= {csr_era[31:2], 2'b00};
            ertn_count  <= ertn_count + 16'd1;
          end
        end
        FLUSH: begin
          state          <= REDIRECT;
          flush          <= 1'b0;
          redirect_valid <= 1'b1;
        end
        REDIRECT: begin
          if (if_redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flush_ctrl.sv
module tb_flush_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex;
  logic [31:0] wb_ex_pc;
  logic [5:0]  wb_ecode;
  logic        ertn_flush;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        if_redirect_ready;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [31:0] last_ex_pc;
  logic [5:0]  last_ecode;
  logic [15:0] ex_count;
  logic [15:0] ertn_count;

  flush_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_ex             (wb_ex),
    .wb_ex_pc          (wb_ex_pc),
    .wb_ecode          (wb_ecode),
    .ertn_flush        (ertn_flush),
    .csr_eentry        (csr_eentry),
    .csr_era           (csr_era),
    .if_redirect_ready (if_redirect_ready),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .busy              (busy),
    .last_ex_pc        (last_ex_pc),
    .last_ecode        (last_ecode),
    .ex_count          (ex_count),
    .ertn_count        (ertn_count)
  );

  always #5 clk = ~clk;

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;
  logic [31:0]  exp_q[$];
  logic [15:0]  model_ex   = 16'h0;
  logic [15:0]  model_ertn = 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one event for a single cycle. Push the target the model expects.
  // Then check the flush pulse on the following cycle.
  task automatic send(input bit ex, input bit er, input string tag);
    wb_ex      = ex;
    ertn_flush = er;
    if (ex) begin
      exp_q.push_back({csr_eentry[31:2], 2'b00});
      model_ex++;
    end else if (er) begin
      exp_q.push_back({csr_era[31:2], 2'b00});
      model_ertn++;
    end
    tick();
    wb_ex      = 1'b0;
    ertn_flush = 1'b0;
    chk({tag, "_flush"}, {31'h0, flush}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
  endtask

  // Bounded wait for redirect_valid. Then pop the scoreboard and compare.
  task automatic expect_redirect(input string tag);
    logic [31:0] exp;
    int          cyc;
    cyc = 0;
    while (!redirect_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!redirect_valid) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_timeout observed=0 expected=redirect_valid", tag);
    end else if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb_empty observed=%h expected=none", tag, redirect_pc);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_pc"}, redirect_pc, exp);
    end
  endtask

  initial begin
    logic [31:0] held_pc;
    int          n_pre;
    resetn = 1'b0;
    wb_ex = 1'b0; wb_ex_pc = 32'h0; wb_ecode = 6'h0; ertn_flush = 1'b0;
    csr_eentry = 32'h1C008000; csr_era = 32'h0; if_redirect_ready = 1'b1;
    #12;
    chk("rst_valid", {31'h0, redirect_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_ex_count", {16'h0, ex_count}, 32'h0);
    resetn = 1'b1;
    tick();

    // Basic exception, minimum latency.
    wb_ex_pc = 32'h1C000100; wb_ecode = 6'h0B;
    send(1'b1, 1'b0, "basic");
    chk("basic_valid_c1", {31'h0, redirect_valid}, 32'h0);
    tick();
    chk("basic_flush_c2", {31'h0, flush}, 32'h0);
    expect_redirect("basic");
    chk("basic_pc_const", redirect_pc, 32'h1C008000);
    tick();
    chk("basic_idle_valid", {31'h0, redirect_valid}, 32'h0);
    chk("basic_idle_busy", {31'h0, busy}, 32'h0);
    chk("basic_ex_count", {16'h0, ex_count}, {16'h0, model_ex});
    chk("basic_ecode", {26'h0, last_ecode}, 32'h0B);
    chk("basic_ex_pc", last_ex_pc, 32'h1C000100);

    // ertn back-to-back on the cycle after returning to IDLE.
    csr_era = 32'h1C000107;
    send(1'b0, 1'b1, "ertn");
    expect_redirect("ertn");
    chk("ertn_pc_const", redirect_pc, 32'h1C000104);
    tick();
    chk("ertn_count", {16'h0, ertn_count}, 32'h1);
    chk("ertn_ex_count", {16'h0, ex_count}, {16'h0, model_ex});

    // Simultaneous exception and ertn: the exception wins.
    csr_eentry = 32'h1C00A003; wb_ex_pc = 32'h1C000200; wb_ecode = 6'h15;
    send(1'b1, 1'b1, "simul");
    expect_redirect("simul");
    tick();
    chk("simul_ex_count", {16'h0, ex_count}, 32'h2);
    chk("simul_ertn_count", {16'h0, ertn_count}, {16'h0, model_ertn});
    chk("simul_ecode", {26'h0, last_ecode}, 32'h15);

    // Backpressure: hold for 5 cycles and ignore events and CSR changes.
    if_redirect_ready = 1'b0;
    csr_eentry = 32'h1C00C000; wb_ex_pc = 32'h1C000300; wb_ecode = 6'h08;
    send(1'b1, 1'b0, "bp");
    tick();
    held_pc = redirect_pc;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, redirect_valid}, 32'h1);
      chk("bp_busy", {31'h0, busy}, 32'h1);
      chk("bp_pc_stable", redirect_pc, held_pc);
      if (i == 1) wb_ex = 1'b1;
      if (i == 2) begin wb_ex = 1'b0; ertn_flush = 1'b1; end
      if (i == 3) ertn_flush = 1'b0;
      csr_eentry = 32'h2000_0000 + i * 32'h100;
      wb_ex_pc = 32'hDEAD_0000 + i;
      tick();
    end
    if_redirect_ready = 1'b1;
    expect_redirect("bp");
    tick();
    chk("bp_idle_busy", {31'h0, busy}, 32'h0);
    chk("bp_ex_count", {16'h0, ex_count}, {16'h0, model_ex});
    chk("bp_ertn_count", {16'h0, ertn_count}, {16'h0, model_ertn});
    chk("bp_last_pc", last_ex_pc, 32'h1C000300);

    // Counter wrap: drive exceptions until ex_count reaches 0xFFFF.
    n_pre = 65535 - int'(model_ex);
    for (int i = 0; i < n_pre; i++) begin
      wb_ex = 1'b1;
      tick();
      wb_ex = 1'b0;
      tick();
      tick();
    end
    model_ex = 16'hFFFF;
    chk("wrap_pre", {16'h0, ex_count}, 32'h0000FFFF);
    csr_eentry = 32'h1C00E000;
    send(1'b1, 1'b0, "wrap");
    model_ex = 16'h0000;
    expect_redirect("wrap");
    tick();
    chk("wrap_ex_count", {16'h0, ex_count}, {16'h0, model_ex});

    // Reset asserted in REDIRECT: aborts at once and nothing follows.
    if_redirect_ready = 1'b0;
    csr_eentry = 32'h1C00F000;
    send(1'b1, 1'b0, "rst_mid");
    tick();
    chk("rst_mid_in_redirect", {31'h0, redirect_valid}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, redirect_valid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_flush", {31'h0, flush}, 32'h0);
    chk("rst_mid_pc", redirect_pc, 32'h0);
    chk("rst_mid_last_pc", last_ex_pc, 32'h0);
    chk("rst_mid_counts", {ex_count, ertn_count}, 32'h0);
    exp_q.delete();
    model_ex = 16'h0;
    model_ertn = 16'h0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", {31'h0, redirect_valid}, 32'h0);
      chk("post_rst_flush", {31'h0, flush}, 32'h0);
    end

    // An event presented before the first edge after release is accepted.
    resetn = 1'b0;
    #1;
    if_redirect_ready = 1'b1;
    csr_era = 32'h1C0000FF;
    ertn_flush = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    send(1'b0, 1'b1, "first_edge");
    expect_redirect("first_edge");
    chk("first_edge_pc_const", redirect_pc, 32'h1C0000FC);
    tick();
    chk("first_edge_ertn", {16'h0, ertn_count}, {16'h0, model_ertn});
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
